// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Brief    : SPI Mode 0 serial-flash target (READ 0x03, WREN 0x06, PP 0x02)
//            backed by an internal byte array; all pins oversampled on clk.
//            Optional READ STATUS (0x05) when SPI_FLASH_RESP_STATUS_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int MEM_ADDR_W  = 12,
  parameter int PAGE_W      = 8,
  parameter int BUSY_CYCLES = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_SPI_CLK,
  input  logic i_SPI_MOSI,
  input  logic i_SPI_CS,
  output logic o_SPI_MISO,
  output logic o_SPI_MISO_OE,
  output logic o_WIP,
  output logic o_WEL
);

  localparam int c_BUSY_W = $clog2(BUSY_CYCLES + 1);
  localparam logic [7:0] c_OP_PROGRAM = 8'h02;
  localparam logic [7:0] c_OP_READ    = 8'h03;
  localparam logic [7:0] c_OP_WREN    = 8'h06;
`ifdef SPI_FLASH_RESP_STATUS_EN
  localparam logic [7:0] c_OP_STATUS  = 8'h05;
`endif
  localparam logic [c_BUSY_W-1:0]   c_BUSY_LOAD = c_BUSY_W'(BUSY_CYCLES);
  localparam logic [c_BUSY_W-1:0]   c_BUSY_ONE  = c_BUSY_W'(1);
  localparam logic [MEM_ADDR_W-1:0] c_ADDR_ONE  = MEM_ADDR_W'(1);
  localparam logic [PAGE_W-1:0]     c_PAGE_ONE  = PAGE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_RDATA  = 3'd3,
    ST_PDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  logic r_sck_s1, r_sck_s2, r_sck_h;
  logic r_cs_s1, r_cs_s2, r_cs_h;
  logic r_mosi_s1, r_mosi_s2;

  state_t                r_state, w_state_next;
  logic [4:0]            r_bit_cnt;
  logic [7:0]            r_shift_in;
  logic [7:0]            r_shift_out;
  logic [2:0]            r_out_cnt;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic                  r_is_read;
`ifdef SPI_FLASH_RESP_STATUS_EN
  logic                  r_is_status;
`endif
  logic                  r_oe;
  logic                  r_wel;
  logic                  r_wip;
  logic                  r_program_seen;
  logic [c_BUSY_W-1:0]   r_busy_cnt;
  logic [7:0]            r_mem [0:(2**MEM_ADDR_W)-1];

  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic [7:0] w_shift_in_next;
  logic [7:0] w_rd_byte;
  logic       w_prog_ok;
  logic       w_mem_we;

  // CS flops reset low so a CS already held low at reset release is not seen as a fall
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_h   <= 1'b0;
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_cs_h    <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= i_SPI_CLK;
      r_sck_s2  <= r_sck_s1;
      r_sck_h   <= r_sck_s2;
      r_cs_s1   <= i_SPI_CS;
      r_cs_s2   <= r_cs_s1;
      r_cs_h    <= r_cs_s2;
      r_mosi_s1 <= i_SPI_MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sck_rise      = r_sck_s2 & ~r_sck_h;
  assign w_sck_fall      = ~r_sck_s2 & r_sck_h;
  assign w_cs_rise       = r_cs_s2 & ~r_cs_h;
  assign w_cs_fall       = ~r_cs_s2 & r_cs_h;
  assign w_shift_in_next = {r_shift_in[6:0], r_mosi_s2};
  assign w_prog_ok       = r_wel & ~r_wip;
  assign w_mem_we        = ~w_cs_rise & ~w_cs_fall & w_sck_rise &
                           (r_state == ST_PDATA) & (r_bit_cnt == 5'd7);

  always_comb begin
    w_rd_byte = r_wip ? 8'hFF : r_mem[r_addr];
`ifdef SPI_FLASH_RESP_STATUS_EN
    if (r_is_status) w_rd_byte = {6'b0, r_wel, r_wip};
`endif
  end

  always_comb begin
    w_state_next = r_state;
    if (w_cs_rise) begin
      w_state_next = ST_IDLE;
    end else if (w_cs_fall) begin
      w_state_next = ST_CMD;
    end else if (w_sck_rise) begin
      case (r_state)
        ST_CMD: begin
          if (r_bit_cnt == 5'd7) begin
            if (w_shift_in_next == c_OP_READ)
              w_state_next = ST_ADDR;
            else if ((w_shift_in_next == c_OP_PROGRAM) && w_prog_ok)
              w_state_next = ST_ADDR;
`ifdef SPI_FLASH_RESP_STATUS_EN
            else if (w_shift_in_next == c_OP_STATUS)
              w_state_next = ST_RDATA;
`endif
            else
              w_state_next = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          if (r_bit_cnt == 5'd23) w_state_next = r_is_read ? ST_RDATA : ST_PDATA;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= 5'd0;
      r_shift_in     <= 8'h00;
      r_shift_out    <= 8'h00;
      r_out_cnt      <= 3'd0;
      r_addr         <= '0;
      r_is_read      <= 1'b0;
`ifdef SPI_FLASH_RESP_STATUS_EN
      r_is_status    <= 1'b0;
`endif
      r_oe           <= 1'b0;
      r_wel          <= 1'b0;
      r_wip          <= 1'b0;
      r_program_seen <= 1'b0;
      r_busy_cnt     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_wip) begin
        r_busy_cnt <= r_busy_cnt - c_BUSY_ONE;
        if (r_busy_cnt == c_BUSY_ONE) r_wip <= 1'b0;
      end
      if (w_cs_rise) begin
        r_oe           <= 1'b0;
        r_program_seen <= 1'b0;
        if (r_program_seen) begin
          r_wel      <= 1'b0;
          r_wip      <= 1'b1;
          r_busy_cnt <= c_BUSY_LOAD;
        end
      end else if (w_cs_fall) begin
        r_bit_cnt      <= 5'd0;
        r_out_cnt      <= 3'd0;
        r_oe           <= 1'b0;
        r_program_seen <= 1'b0;
        r_is_read      <= 1'b0;
`ifdef SPI_FLASH_RESP_STATUS_EN
        r_is_status    <= 1'b0;
`endif
      end else if (w_sck_rise) begin
        r_shift_in <= w_shift_in_next;
        case (r_state)
          ST_CMD: begin
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              r_is_read <= (w_shift_in_next == c_OP_READ);
              if (w_shift_in_next == c_OP_WREN) r_wel <= 1'b1;
`ifdef SPI_FLASH_RESP_STATUS_EN
              r_is_status <= (w_shift_in_next == c_OP_STATUS);
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          ST_ADDR: begin
            r_addr    <= {r_addr[MEM_ADDR_W-2:0], r_mosi_s2};
            r_bit_cnt <= (r_bit_cnt == 5'd23) ? 5'd0 : r_bit_cnt + 5'd1;
          end
          ST_PDATA: begin
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt      <= 5'd0;
              r_addr         <= {r_addr[MEM_ADDR_W-1:PAGE_W], r_addr[PAGE_W-1:0] + c_PAGE_ONE};
              r_program_seen <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end else if (w_sck_fall && (r_state == ST_RDATA)) begin
        // Byte boundary every 8th fall: load the next byte, otherwise shift MSB-first
        r_out_cnt <= r_out_cnt + 3'd1;
        if (r_out_cnt == 3'd0) begin
          r_shift_out <= w_rd_byte;
          r_addr      <= r_addr + c_ADDR_ONE;
          r_oe        <= 1'b1;
        end else begin
          r_shift_out <= {r_shift_out[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) r_mem[r_addr] <= w_shift_in_next;
  end

  assign o_SPI_MISO    = r_oe & r_shift_out[7];
  assign o_SPI_MISO_OE = r_oe;
  assign o_WIP         = r_wip;
  assign o_WEL         = r_wel;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Brief    : Directed self-checking bench for spi_flash_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam int BUSY = 1000;

  logic clk = 1'b0;
  logic reset;
  logic i_SPI_CLK;
  logic i_SPI_MOSI;
  logic i_SPI_CS;
  logic o_SPI_MISO;
  logic o_SPI_MISO_OE;
  logic o_WIP;
  logic o_WEL;

  int tests = 0;
  int fails = 0;

  logic [7:0] txq[$];
  logic [7:0] rx_buf [0:15];
  logic       oe_seen;

  always #5 clk = ~clk;

  spi_flash_responder #(
    .MEM_ADDR_W (12),
    .PAGE_W     (8),
    .BUSY_CYCLES(BUSY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_SPI_CLK    (i_SPI_CLK),
    .i_SPI_MOSI   (i_SPI_MOSI),
    .i_SPI_CS     (i_SPI_CS),
    .o_SPI_MISO   (o_SPI_MISO),
    .o_SPI_MISO_OE(o_SPI_MISO_OE),
    .o_WIP        (o_WIP),
    .o_WEL        (o_WEL)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 bit transfer: 4 clk low phase, sample MISO at the rise, 4 clk high
  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      i_SPI_MOSI = tx[7-i];
      idle(4);
      i_SPI_CLK = 1'b1;
      rx[7-i] = o_SPI_MISO;
      if (o_SPI_MISO_OE) oe_seen = 1'b1;
      idle(4);
      i_SPI_CLK = 1'b0;
    end
  endtask

  // Full CS-framed transaction of txq; returns on the edge that raises CS
  task automatic run_txn();
    logic [7:0] b;
    oe_seen  = 1'b0;
    i_SPI_CS = 1'b0;
    idle(4);
    foreach (txq[k]) begin
      xfer_bits(txq[k], 8, b);
      rx_buf[k] = b;
    end
    idle(4);
    i_SPI_CS = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_SPI_CS = 1'b1; i_SPI_CLK = 1'b0; i_SPI_MOSI = 1'b0;
    idle(5);
    reset = 1'b0;
    idle(3);
    tests++; if (o_WIP !== 1'b0) begin fails++; $display("FAIL reset_wip got=%b exp=0", o_WIP); end
    tests++; if (o_WEL !== 1'b0) begin fails++; $display("FAIL reset_wel got=%b exp=0", o_WEL); end
    tests++; if (o_SPI_MISO_OE !== 1'b0) begin fails++; $display("FAIL reset_oe got=%b exp=0", o_SPI_MISO_OE); end
    tests++; if (o_SPI_MISO !== 1'b0) begin fails++; $display("FAIL reset_miso got=%b exp=0", o_SPI_MISO); end
  endtask

  task automatic test_write_enable();
    txq = '{8'h06}; run_txn(); idle(6);
    tests++; if (o_WEL !== 1'b1) begin fails++; $display("FAIL wren_wel got=%b exp=1", o_WEL); end
    tests++; if (o_WIP !== 1'b0) begin fails++; $display("FAIL wren_wip got=%b exp=0", o_WIP); end
  endtask

  task automatic test_program_busy();
    int k;
    int cnt;
    txq = '{8'h02, 8'h00, 8'h01, 8'h23, 8'hA5, 8'h3C}; run_txn();
    k = 0;
    while (!o_WIP && k < 20) begin @(negedge clk); k++; end
    tests++; if (o_WIP !== 1'b1) begin fails++; $display("FAIL prog_wip_rise got=%b exp=1", o_WIP); end
    cnt = 0;
    while (o_WIP && cnt < 3 * BUSY) begin cnt++; @(negedge clk); end
    tests++; if (cnt != BUSY) begin fails++; $display("FAIL prog_wip_len got=%0d exp=%0d", cnt, BUSY); end
    tests++; if (o_WEL !== 1'b0) begin fails++; $display("FAIL prog_wel_clear got=%b exp=0", o_WEL); end
    idle(4);
  endtask

  task automatic test_read();
    txq = '{8'h03, 8'h00, 8'h01, 8'h23, 8'h00, 8'h00}; run_txn();
    tests++; if (oe_seen !== 1'b1) begin fails++; $display("FAIL read_oe_on got=%b exp=1", oe_seen); end
    idle(6);
    tests++; if (rx_buf[4] !== 8'hA5) begin fails++; $display("FAIL read_b0 got=%h exp=a5", rx_buf[4]); end
    tests++; if (rx_buf[5] !== 8'h3C) begin fails++; $display("FAIL read_b1 got=%h exp=3c", rx_buf[5]); end
    tests++; if (o_SPI_MISO_OE !== 1'b0) begin fails++; $display("FAIL read_oe_off got=%b exp=0", o_SPI_MISO_OE); end
  endtask

  task automatic test_page_wrap();
    txq = '{8'h06}; run_txn(); idle(6);
    txq = '{8'h02, 8'h00, 8'h02, 8'hFF, 8'h11, 8'h22}; run_txn(); idle(BUSY + 20);
    txq = '{8'h03, 8'h00, 8'h02, 8'hFF, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[4] !== 8'h11) begin fails++; $display("FAIL wrap_2ff got=%h exp=11", rx_buf[4]); end
    txq = '{8'h03, 8'h00, 8'h02, 8'h00, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[4] !== 8'h22) begin fails++; $display("FAIL wrap_200 got=%h exp=22", rx_buf[4]); end
  endtask

  task automatic test_no_wel();
    txq = '{8'h06}; run_txn(); idle(6);
    txq = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h77}; run_txn(); idle(BUSY + 20);
    txq = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h55}; run_txn(); idle(10);
    tests++; if (o_WIP !== 1'b0) begin fails++; $display("FAIL nowel_wip got=%b exp=0", o_WIP); end
    tests++; if (o_WEL !== 1'b0) begin fails++; $display("FAIL nowel_wel got=%b exp=0", o_WEL); end
    txq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[4] !== 8'h77) begin fails++; $display("FAIL nowel_mem got=%h exp=77", rx_buf[4]); end
  endtask

  task automatic test_partial_byte();
    logic [7:0] b;
    txq = '{8'h06}; run_txn(); idle(6);
    i_SPI_CS = 1'b0; idle(4);
    xfer_bits(8'h02, 8, b); xfer_bits(8'h00, 8, b);
    xfer_bits(8'h05, 8, b); xfer_bits(8'h00, 8, b);
    xfer_bits(8'hAB, 4, b);
    idle(4); i_SPI_CS = 1'b1; idle(10);
    tests++; if (o_WIP !== 1'b0) begin fails++; $display("FAIL partial_wip got=%b exp=0", o_WIP); end
    tests++; if (o_WEL !== 1'b1) begin fails++; $display("FAIL partial_wel got=%b exp=1", o_WEL); end
  endtask

  task automatic test_read_busy();
    txq = '{8'h06}; run_txn(); idle(6);
    txq = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h5A}; run_txn(); idle(6);
    tests++; if (o_WIP !== 1'b1) begin fails++; $display("FAIL busy_wip got=%b exp=1", o_WIP); end
    txq = '{8'h03, 8'h00, 8'h01, 8'h23, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[4] !== 8'hFF) begin fails++; $display("FAIL busy_read got=%h exp=ff", rx_buf[4]); end
`ifdef SPI_FLASH_RESP_STATUS_EN
    txq = '{8'h06}; run_txn(); idle(6);
    txq = '{8'h05, 8'h00, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[1] !== 8'h03) begin fails++; $display("FAIL status_busy0 got=%h exp=03", rx_buf[1]); end
    tests++; if (rx_buf[2] !== 8'h03) begin fails++; $display("FAIL status_busy1 got=%h exp=03", rx_buf[2]); end
    tests++; if (o_WIP !== 1'b1) begin fails++; $display("FAIL status_still_busy got=%b exp=1", o_WIP); end
    idle(BUSY + 20);
    txq = '{8'h02, 8'h00, 8'h04, 8'h01, 8'h66}; run_txn(); idle(BUSY + 20);
    txq = '{8'h05, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[1] !== 8'h00) begin fails++; $display("FAIL status_idle got=%h exp=00", rx_buf[1]); end
`else
    txq = '{8'h05, 8'h00, 8'h00}; run_txn(); idle(6);
    tests++; if (oe_seen !== 1'b0) begin fails++; $display("FAIL status_off_oe got=%b exp=0", oe_seen); end
    tests++; if (rx_buf[1] !== 8'h00) begin fails++; $display("FAIL status_off_miso got=%h exp=00", rx_buf[1]); end
    idle(BUSY + 20);
`endif
  endtask

  task automatic test_addr_wrap();
    txq = '{8'h06}; run_txn(); idle(6);
    txq = '{8'h02, 8'h00, 8'h0F, 8'hFF, 8'h9C}; run_txn(); idle(BUSY + 20);
    txq = '{8'h06}; run_txn(); idle(6);
    txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hE7}; run_txn(); idle(BUSY + 20);
    // upper address bits are don't-care: 0xABCFFF selects byte 0xFFF
    txq = '{8'h03, 8'hAB, 8'hCF, 8'hFF, 8'h00, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[4] !== 8'h9C) begin fails++; $display("FAIL awrap_fff got=%h exp=9c", rx_buf[4]); end
    tests++; if (rx_buf[5] !== 8'hE7) begin fails++; $display("FAIL awrap_000 got=%h exp=e7", rx_buf[5]); end
  endtask

  task automatic test_reset_mid_addr();
    logic [7:0] b;
    logic [7:0] b_any;
    oe_seen = 1'b0;
    b_any   = 8'h00;
    i_SPI_CS = 1'b0; idle(4);
    xfer_bits(8'h03, 8, b); xfer_bits(8'h00, 8, b);
    reset = 1'b1; idle(3); reset = 1'b0;
    xfer_bits(8'h01, 8, b); b_any = b_any | b;
    xfer_bits(8'h23, 8, b); b_any = b_any | b;
    xfer_bits(8'h00, 8, b); b_any = b_any | b;
    xfer_bits(8'h00, 8, b); b_any = b_any | b;
    tests++; if (oe_seen !== 1'b0) begin fails++; $display("FAIL rstmid_oe got=%b exp=0", oe_seen); end
    tests++; if (b_any !== 8'h00) begin fails++; $display("FAIL rstmid_miso got=%h exp=00", b_any); end
    idle(4); i_SPI_CS = 1'b1; idle(6);
    txq = '{8'h03, 8'h00, 8'h01, 8'h23, 8'h00}; run_txn(); idle(6);
    tests++; if (rx_buf[4] !== 8'hA5) begin fails++; $display("FAIL rstmid_read got=%h exp=a5", rx_buf[4]); end
  endtask

  initial begin
    test_reset();
    test_write_enable();
    test_program_busy();
    test_read();
    test_page_wrap();
    test_no_wel();
    test_partial_byte();
    test_read_busy();
    test_addr_wrap();
    test_reset_mid_addr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
